// File: rtl/coprosit_alu_pipe.sv
// Two-stage elastic posit compare/min/max/neg/abs unit for the Coprosit coprocessor.
// S1 registers operands plus compare flags; S2 registers the final zero-extended result.
module coprosit_alu_pipe #(
    parameter int unsigned POSLEN = 32,
    parameter int unsigned XLEN   = 64,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [POSLEN-1:0] operand_a_i,
    input  logic [POSLEN-1:0] operand_b_i,
    input  logic [2:0]        op_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              busy_o
);

    generate
        if (POSLEN < 2) begin : g_bad_poslen
            $error("coprosit_alu_pipe: POSLEN must be >= 2");
        end
        if (XLEN < POSLEN) begin : g_bad_xlen
            $error("coprosit_alu_pipe: XLEN must be >= POSLEN");
        end
    endgenerate

    typedef enum logic [2:0] {
        OP_EQ  = 3'd0,
        OP_LT  = 3'd1,
        OP_LE  = 3'd2,
        OP_MIN = 3'd3,
        OP_MAX = 3'd4,
        OP_NEG = 3'd5,
        OP_ABS = 3'd6,
        OP_RSV = 3'd7
    } op_e;

    typedef struct packed {
        logic [POSLEN-1:0] a;
        logic [POSLEN-1:0] b;
        op_e               op;
        logic [TAG_W-1:0]  tag;
        logic              less;
        logic              equal;
    } s1_t;

    s1_t              s1_q, s1_d;
    logic             s1_vld_q, s1_vld_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             out_vld_q, out_vld_d;

    logic s2_adv, accept;

    // Posit order equals two's-complement integer order; NaR is the most negative code.
    logic signed [POSLEN:0] a_ext, b_ext;
    logic                   less_in, equal_in;

    assign a_ext    = {operand_a_i[POSLEN-1], operand_a_i};
    assign b_ext    = {operand_b_i[POSLEN-1], operand_b_i};
    assign less_in  = a_ext < b_ext;
    assign equal_in = operand_a_i == operand_b_i;

    assign s2_adv     = s1_vld_q & (~out_vld_q | out_ready_i);
    assign in_ready_o = ~flush_i & (~s1_vld_q | s2_adv);
    assign accept     = in_valid_i & in_ready_o;

    // NEG wraps mod 2^POSLEN, so 0 and NaR map to themselves.
    logic [POSLEN-1:0] neg_a;
    logic [XLEN-1:0]   res_calc;

    assign neg_a = ~s1_q.a + POSLEN'(1);

    always_comb begin
        res_calc = '0;
        case (s1_q.op)
            OP_EQ:   res_calc[0] = s1_q.equal;
            OP_LT:   res_calc[0] = s1_q.less;
            OP_LE:   res_calc[0] = s1_q.less | s1_q.equal;
            OP_MIN:  res_calc[POSLEN-1:0] = s1_q.less ? s1_q.a : s1_q.b;
            OP_MAX:  res_calc[POSLEN-1:0] = s1_q.less ? s1_q.b : s1_q.a;
            OP_NEG:  res_calc[POSLEN-1:0] = neg_a;
            OP_ABS:  res_calc[POSLEN-1:0] = s1_q.a[POSLEN-1] ? neg_a : s1_q.a;
            OP_RSV:  res_calc = '0;
            default: res_calc = '0;
        endcase
    end

    always_comb begin
        s1_d      = s1_q;
        s1_vld_d  = s1_vld_q;
        res_d     = res_q;
        tag_d     = tag_q;
        out_vld_d = out_vld_q;
        if (flush_i) begin
            s1_vld_d  = 1'b0;
            out_vld_d = 1'b0;
            res_d     = '0;
            tag_d     = '0;
        end else begin
            if (accept) begin
                s1_vld_d   = 1'b1;
                s1_d.a     = operand_a_i;
                s1_d.b     = operand_b_i;
                s1_d.op    = op_e'(op_i);
                s1_d.tag   = tag_i;
                s1_d.less  = less_in;
                s1_d.equal = equal_in;
            end else if (s2_adv) begin
                s1_vld_d = 1'b0;
            end

            if (s2_adv) begin
                out_vld_d = 1'b1;
                res_d     = res_calc;
                tag_d     = s1_q.tag;
            end else if (out_vld_q & out_ready_i) begin
                // Drained with nothing behind it: leave a clean idle output.
                out_vld_d = 1'b0;
                res_d     = '0;
                tag_d     = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q      <= '0;
            s1_vld_q  <= 1'b0;
            res_q     <= '0;
            tag_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s1_vld_q  <= s1_vld_d;
            res_q     <= res_d;
            tag_q     <= tag_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign out_valid_o = out_vld_q;
    assign result_o    = res_q;
    assign tag_o       = tag_q;
    assign busy_o      = s1_vld_q | out_vld_q;

endmodule

// File: tb/tb_coprosit_alu_pipe.sv
// Scoreboard bench for coprosit_alu_pipe: driver pushes reference results on accept,
// a negedge monitor pops and compares on every output handshake.
module tb_coprosit_alu_pipe;
    localparam int P = 16;
    localparam int X = 32;
    localparam int T = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         flush_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [P-1:0] operand_a_i = '0;
    logic [P-1:0] operand_b_i = '0;
    logic [2:0]   op_i = '0;
    logic [T-1:0] tag_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b1;
    logic [X-1:0] result_o;
    logic [T-1:0] tag_o;
    logic         busy_o;

    coprosit_alu_pipe #(.POSLEN(P), .XLEN(X), .TAG_W(T)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .op_i(op_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .tag_o(tag_o), .busy_o(busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic [X-1:0] res;
        logic [T-1:0] tag;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    bit   chk_lat = 1'b0;
    bit   rnd_on = 1'b0;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: posit order is integer order of the bit pattern read as two's complement.
    function automatic logic [X-1:0] model(input logic [P-1:0] a, input logic [P-1:0] b,
                                           input logic [2:0] op);
        int va, vb, na;
        logic [P-1:0] neg;
        va  = int'($signed(a));
        vb  = int'($signed(b));
        na  = (65536 - int'({16'd0, a})) % 65536;
        neg = na[15:0];
        case (op)
            3'd0: return {31'd0, va == vb};
            3'd1: return {31'd0, va < vb};
            3'd2: return {31'd0, va <= vb};
            3'd3: return {16'd0, (va < vb) ? a : b};
            3'd4: return {16'd0, (va < vb) ? b : a};
            3'd5: return {16'd0, neg};
            3'd6: return {16'd0, a[15] ? neg : a};
            default: return '0;
        endcase
    endfunction

    // Monitor / scoreboard, sampling at negedge (inputs change at posedge+1).
    logic         hold_vld = 1'b0;
    logic [X-1:0] hold_res;
    logic [T-1:0] hold_tag;
    initial forever begin
        exp_t e;
        @(negedge clk_i);
        if (!rst_ni || flush_i) begin
            q.delete();
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                if (!out_valid_o) chk("hold_valid", {31'd0, out_valid_o}, 32'd1);
                else begin
                    chk("hold_result", result_o, hold_res);
                    chk("hold_tag", {28'd0, tag_o}, {28'd0, hold_tag});
                end
            end
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) chk("spurious_out", {31'd0, out_valid_o}, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("result", result_o, e.res);
                    chk("tag", {28'd0, tag_o}, {28'd0, e.tag});
                    if (chk_lat) chk("latency", cyc - e.cyc, 32'd2);
                end
            end
            hold_vld = out_valid_o && !out_ready_i;
            hold_res = result_o;
            hold_tag = tag_o;
            if (in_valid_i && in_ready_o) begin
                e.res = model(operand_a_i, operand_b_i, op_i);
                e.tag = tag_i;
                e.cyc = cyc;
                q.push_back(e);
                acc_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [P-1:0] a, input logic [P-1:0] b, input logic [2:0] op,
                        input logic [T-1:0] tag);
        int n = 0;
        in_valid_i = 1'b1; operand_a_i = a; operand_b_i = b; op_i = op; tag_i = tag;
        forever begin
            @(negedge clk_i);
            if (in_ready_o) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_empty", q.size(), 32'd0);
        repeat (2) step();
    endtask

    function automatic logic [P-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'h0001;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] cmp_ops [5];
        logic [P-1:0] a, b;
        int a0;
        bit acc;
        logic [T-1:0] t;
        cmp_ops = '{3'd1, 3'd2, 3'd0, 3'd3, 3'd4};

        #23 rst_ni = 1'b1;
        step();
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_tag", {28'd0, tag_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

        // Compare set, back-to-back, latency checked
        chk_lat = 1'b1;
        for (int i = 0; i < 5; i++) send(16'h4000, 16'hC000, cmp_ops[i], T'(i));
        drain();
        chk_lat = 1'b0;

        // NaR / zero boundaries
        send(16'h8000, 16'h0001, 3'd1, 4'd1);
        send(16'h8000, 16'h8000, 3'd0, 4'd2);
        send(16'h8000, 16'h0000, 3'd5, 4'd3);
        send(16'h8000, 16'h0000, 3'd6, 4'd4);
        send(16'h0000, 16'h0000, 3'd5, 4'd5);
        send(16'hC000, 16'h0000, 3'd6, 4'd6);
        send(16'h1234, 16'h5678, 3'd7, 4'd7);
        drain();

        // Backpressure: exactly two absorbed
        out_ready_i = 1'b0;
        a0 = acc_cnt;
        t = 4'd8;
        in_valid_i = 1'b1;
        operand_a_i = pick(); operand_b_i = pick(); op_i = 3'($urandom_range(0, 6)); tag_i = t;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            acc = in_ready_o;
            if (k >= 2) chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
            step();
            if (acc) begin
                t = t + 4'd1;
                operand_a_i = pick(); operand_b_i = pick(); op_i = 3'($urandom_range(0, 6)); tag_i = t;
            end
        end
        in_valid_i = 1'b0;
        chk("bp_accepts", acc_cnt - a0, 32'd2);
        out_ready_i = 1'b1;
        #1 chk("bp_ready_comb", {31'd0, in_ready_o}, 32'd1);
        drain();

        // Handshake clear after a lone op
        send(16'h1234, 16'h0100, 3'd4, 4'd5);
        repeat (3) @(negedge clk_i);
        chk("clr_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("clr_result", result_o, 32'd0);
        chk("clr_tag", {28'd0, tag_o}, 32'd0);
        chk("clr_busy", {31'd0, busy_o}, 32'd0);
        step();

        // Flush with two in flight
        send(16'h0100, 16'h0200, 3'd3, 4'd1);
        send(16'h0300, 16'h0400, 3'd4, 4'd2);
        flush_i = 1'b1;
        in_valid_i = 1'b1; operand_a_i = 16'h0005; operand_b_i = 16'h0006; op_i = 3'd1; tag_i = 4'd3;
        @(negedge clk_i);
        chk("flush_in_ready", {31'd0, in_ready_o}, 32'd0);
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        step();
        send(16'hF000, 16'h0010, 3'd3, 4'd6);
        drain();

        // Async reset with both stages full
        out_ready_i = 1'b0;
        send(16'h2222, 16'h3333, 3'd4, 4'd9);
        send(16'h4444, 16'h5555, 3'd3, 4'd10);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("arst_result", result_o, 32'd0);
        chk("arst_tag", {28'd0, tag_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        out_ready_i = 1'b1;
        step();
        send(16'h0001, 16'h7FFF, 3'd4, 4'd11);
        drain();

        // Randomized traffic with random backpressure and occasional flush
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    if ($urandom_range(0, 39) == 0) begin
                        flush_i = 1'b1;
                        step();
                        flush_i = 1'b0;
                    end else begin
                        a = pick();
                        b = ($urandom_range(0, 5) == 0) ? a : pick();
                        send(a, b, 3'($urandom_range(0, 7)), T'($urandom));
                    end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    step();
                    out_ready_i = ($urandom_range(0, 3) != 0);
                end
                out_ready_i = 1'b1;
            end
        join
        out_ready_i = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
